// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity type constants,
// legal oversampling ratios and small helper functions.
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Parity type encoding (also used by the transmitter)
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Supported oversampling ratios
    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // True when p is one of the supported oversampling ratios
    function automatic logic legal_prescale(input int p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

    // Parity bit a transmitter would send, given the XOR of all data bits
    function automatic logic expected_parity(input logic data_xor, input logic typ);
        logic result;
        case (typ)
            PAR_EVEN: result = data_xor;
            PAR_ODD:  result = ~data_xor;
            default:  result = data_xor;
        endcase
        return result;
    endfunction

    // 2-of-3 majority vote
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing engine for the UART receiver: counts oversampling edges within
// each bit period, raises the sample strobe at mid-bit and the bit-done strobe
// at the last edge of the period.
// Optional macro UART_RX_MAJORITY_EN: the bit value becomes the 2-of-3 vote of
// the samples around mid-bit, decided one edge after mid-bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start,
    input  logic                  busy,
    input  logic                  abort,
    output logic                  sampled_bit,
    output logic                  sample_stb,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt_reg;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] decide_pt;

    assign half      = prescale_reg >> 1;
    assign last_edge = prescale_reg - ONE;

    // Freeze the oversampling ratio for the whole frame at start detection
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_reg <= '0;
        end else if (start) begin
            prescale_reg <= prescale;
        end
    end

    // Edge counter: the detecting cycle is edge 0, so a new frame resumes at 1
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            edge_cnt_reg <= '0;
        end else if (start) begin
            edge_cnt_reg <= ONE;
        end else if (busy) begin
            edge_cnt_reg <= (edge_cnt_reg == last_edge) ? '0 : edge_cnt_reg + ONE;
        end else begin
            edge_cnt_reg <= '0;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Two-deep history so the vote at mid-bit+1 sees mid-bit-1 and mid-bit
    logic [1:0] hist_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= 2'b11;
        end else begin
            hist_reg <= {hist_reg[0], rx_in};
        end
    end

    assign decide_pt   = half + ONE;
    assign sampled_bit = majority3(hist_reg[1], hist_reg[0], rx_in);
`else
    assign decide_pt   = half;
    assign sampled_bit = rx_in;
`endif

    assign sample_stb = busy && (edge_cnt_reg == decide_pt);
    assign bit_done   = busy && (edge_cnt_reg == last_edge);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: detects the start bit, shifts in DATA_WIDTH bits LSB first,
// optionally checks parity, checks the stop bit, and reports the frame result
// with one-cycle data_valid / par_err / stop_err pulses.
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling
// (implemented in uart_rx_sampler).
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    rx_state_t state_reg;
    rx_state_t state_next;

    logic start;
    logic busy;
    logic abort;
    logic sampled_bit;
    logic sample_stb;
    logic bit_done;
    logic last_data_bit;
    logic parity_exp;

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] bit_we;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic                  par_mis_reg;

    logic [DATA_WIDTH-1:0] p_data_reg;
    logic [DATA_WIDTH-1:0] p_data_next;
    logic                  data_valid_reg;
    logic                  data_valid_next;
    logic                  par_err_reg;
    logic                  par_err_next;
    logic                  stop_err_reg;
    logic                  stop_err_next;

    assign busy          = (state_reg != IDLE);
    assign start         = !busy && !rx_in;
    assign abort         = busy && (state_next == IDLE);
    assign last_data_bit = (bit_cnt_reg == LAST_BIT);
    assign parity_exp    = expected_parity(^shift_reg, par_typ_reg);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .start       (start),
        .busy        (busy),
        .abort       (abort),
        .sampled_bit (sampled_bit),
        .sample_stb  (sample_stb),
        .bit_done    (bit_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; STOP leaves at the sample point so the next start edge is caught
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (!rx_in) state_next = START;
            end
            START: begin
                if (sample_stb && sampled_bit) state_next = IDLE;
                else if (bit_done)             state_next = DATA;
            end
            DATA: begin
                if (bit_done && last_data_bit) state_next = par_en_reg ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_done) state_next = STOP;
            end
            STOP: begin
                if (sample_stb) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame result decided at the stop-bit sample
    always_comb begin
        data_valid_next = 1'b0;
        par_err_next    = 1'b0;
        stop_err_next   = 1'b0;
        p_data_next     = p_data_reg;
        if (state_reg == STOP && sample_stb) begin
            data_valid_next = sampled_bit && !par_mis_reg;
            par_err_next    = par_mis_reg;
            stop_err_next   = !sampled_bit;
        end
        if (data_valid_next) p_data_next = shift_reg;
    end

    // One write enable per data bit, selected by the current bit index
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_we
            assign bit_we[gi] = (state_reg == DATA) && sample_stb && (bit_cnt_reg == BIT_W'(gi));
        end
    endgenerate

    // Frame datapath: latched config, bit index, received bits, parity mismatch
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= PAR_EVEN;
            par_mis_reg <= 1'b0;
        end else begin
            if (start) begin
                par_en_reg  <= par_en;
                par_typ_reg <= par_typ;
                par_mis_reg <= 1'b0;
                bit_cnt_reg <= '0;
            end
            if (state_reg == DATA && bit_done) begin
                bit_cnt_reg <= last_data_bit ? '0 : bit_cnt_reg + BIT_W'(1);
            end
            if (state_reg == PARITY && sample_stb) begin
                par_mis_reg <= (sampled_bit != parity_exp);
            end
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (bit_we[i]) shift_reg[i] <= sampled_bit;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            p_data_reg     <= '0;
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stop_err_reg   <= 1'b0;
        end else begin
            p_data_reg     <= p_data_next;
            data_valid_reg <= data_valid_next;
            par_err_reg    <= par_err_next;
            stop_err_reg   <= stop_err_next;
        end
    end

    assign p_data     = p_data_reg;
    assign data_valid = data_valid_reg;
    assign par_err    = par_err_reg;
    assign stop_err   = stop_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames, a frame-level expectation queue and
// a per-cycle compare of all outputs, plus literal spot checks.
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;

    uart_rx #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } ev_t;

    ev_t  ev_q[$];
    int   cyc = 0;
    logic rst_q = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   dv_cnt = 0;
    int   pe_cnt = 0;
    int   se_cnt = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Compare process: every cycle, outputs must match the frame-level model
    initial begin
        logic [7:0] p_exp;
        logic       dv_exp, pe_exp, se_exp;
        ev_t        ev;
        p_exp = 8'h00;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                dv_exp = 1'b0;
                pe_exp = 1'b0;
                se_exp = 1'b0;
                if (rst_q) begin
                    p_exp = 8'h00;
                    ev_q.delete();
                end else if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                    ev = ev_q.pop_front();
                    dv_exp = ev.dv;
                    pe_exp = ev.pe;
                    se_exp = ev.se;
                    if (ev.dv) p_exp = ev.data;
                    $display("cycle %0d frame result: data_valid=%0b par_err=%0b stop_err=%0b p_data=%h (dut p_data=%h)",
                             cyc, dv_exp, pe_exp, se_exp, p_exp, p_data);
                end
                checks++;
                if ({data_valid, par_err, stop_err, p_data} !== {dv_exp, pe_exp, se_exp, p_exp}) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got dv=%b pe=%b se=%b p_data=%h, expected dv=%b pe=%b se=%b p_data=%h",
                             cyc, data_valid, par_err, stop_err, p_data, dv_exp, pe_exp, se_exp, p_exp);
                end
                if (data_valid === 1'b1) dv_cnt++;
                if (par_err === 1'b1)    pe_cnt++;
                if (stop_err === 1'b1)   se_cnt++;
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            rx_in = 1'b1;
        end
    endtask

    // Hold one bit for p cycles; optionally invert it for the single mid-bit cycle
    task automatic drive_bit(input logic b, input int p, input logic glitch);
        for (int j = 0; j < p; j++) begin
            @(negedge clk);
            rx_in = (glitch && j == p / 2) ? ~b : b;
        end
    endtask

    // Send one frame and queue the result the receiver must report
    task automatic send_frame(input int p, input logic pe, input logic pt, input logic [7:0] d,
                              input logic flip, input logic stop_v, input int glitch_bit,
                              input logic scramble);
        int   k0;
        int   nbits;
        logic pbit;
        ev_t  ev;
        @(negedge clk);
        prescale = 6'(p);
        par_en   = pe;
        par_typ  = pt;
        rx_in    = 1'b0;
        k0       = cyc + 1;
        nbits    = 9 + (pe ? 1 : 0);
        pbit     = ((^d) ^ pt) ^ flip;
        ev.cyc   = k0 + nbits * p + p / 2 + MAJ;
        ev.pe    = pe && flip;
        ev.se    = !stop_v;
        ev.dv    = !ev.pe && !ev.se;
        ev.data  = d;
        ev_q.push_back(ev);
        $display("cycle %0d send frame data=%h prescale=%0d par_en=%0b par_typ=%0b parity_bit=%0b stop=%0b",
                 k0, d, p, pe, pt, pbit, stop_v);
        for (int j = 1; j < p; j++) begin
            @(negedge clk);
            if (scramble && j == 1) begin
                prescale = (p == 8) ? 6'd16 : 6'd8;
                par_en   = ~pe;
                par_typ  = ~pt;
            end
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, glitch_bit == i);
        if (pe) drive_bit(pbit, p, 1'b0);
        drive_bit(stop_v, p, 1'b0);
    endtask

    initial begin
        int dv_total;
        dv_total = 5;

        // Reset state
        repeat (3) @(negedge clk);
        check_lit("reset_outputs", {21'd0, data_valid, par_err, stop_err, p_data}, 32'd0);
        rst = 1'b0;
        idle(4);

        // Good frame 0xA5, even parity, prescale 8
        send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 1'b0);
        idle(8);
        check_lit("a5_p_data", {24'd0, p_data}, 32'h0000_00A5);
        check_lit("a5_valid_count", dv_cnt, 1);

        // Same frame with the parity bit inverted
        send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, -1, 1'b0);
        idle(8);
        check_lit("par_err_count", pe_cnt, 1);
        check_lit("par_err_no_valid", dv_cnt, 1);

        // Stop bit low at prescale 16, no parity
        send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, -1, 1'b0);
        idle(48);
        check_lit("stop_err_count", se_cnt, 1);
        check_lit("stop_err_p_data_held", {24'd0, p_data}, 32'h0000_00A5);

        // Three-cycle low glitch in IDLE, then frame 0x81
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            prescale = 6'd16;
            par_en   = 1'b0;
            rx_in    = 1'b0;
        end
        idle(40);
        check_lit("glitch_no_pulses", dv_cnt + pe_cnt + se_cnt, 3);
        send_frame(16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, -1, 1'b0);
        idle(16);
        check_lit("x81_p_data", {24'd0, p_data}, 32'h0000_0081);

        // Back-to-back odd-parity frames; config scrambled mid-frame on the second
        send_frame(32, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, -1, 1'b0);
        send_frame(32, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, -1, 1'b1);
        idle(40);
        check_lit("b2b_p_data", {24'd0, p_data}, 32'h0000_00AA);
        check_lit("b2b_valid_count", dv_cnt, 4);

        // Reset in the middle of the data bits of 0xFF, then frame 0x12
        @(negedge clk);
        prescale = 6'd8;
        par_en   = 1'b0;
        rx_in    = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 8, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(16);
        check_lit("mid_reset_p_data", {24'd0, p_data}, 32'd0);
        check_lit("mid_reset_no_valid", dv_cnt, 4);
        send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, -1, 1'b0);
        idle(8);
        check_lit("x12_p_data", {24'd0, p_data}, 32'h0000_0012);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle glitch at the centre sample of data bit 3 is voted out
        send_frame(16, 1'b1, 1'b0, 8'h6B, 1'b0, 1'b1, 3, 1'b0);
        idle(16);
        check_lit("majority_p_data", {24'd0, p_data}, 32'h0000_006B);
        dv_total = 6;
`endif

        idle(8);
        check_lit("total_valid", dv_cnt, dv_total);
        check_lit("total_par_err", pe_cnt, 1);
        check_lit("total_stop_err", se_cnt, 1);
        check_lit("pending_results", ev_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path; the counterpart of the transmit chain (serializer, parity calc, tx output mux).
- Oversamples the serial line at prescale × baud, detects the start bit, and shifts in DATA_WIDTH bits LSB first.
- Optionally checks a parity bit, checks the stop bit, then presents the parallel word with a one-cycle valid pulse.
- Sits between the pad-side rx line and the system-side consumer (FIFO/register file).

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the prescale input and the internal edge counter.

Ports:
- clk  input  1  oversampling clock (prescale × baud rate).
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  serial line; idles high.
- prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- par_en  input  1  1 = frame carries a parity bit.
- par_typ  input  1  0 = even, 1 = odd parity.
- p_data  output  DATA_WIDTH  received word; holds its value until the next valid frame.
- data_valid  output  1  one-cycle pulse when p_data is updated with an error-free frame.
- par_err  output  1  one-cycle pulse: parity mismatch.
- stop_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - p_data = 0; data_valid, par_err, stop_err = 0.
  - state = IDLE; edge_cnt = 0; bit_cnt = 0.
  - Reset mid-frame abandons the frame with no pulses.
- Timing base:
  - edge_cnt counts 0..prescale-1 within each bit period, then wraps to 0 and advances the bit.
  - Sample point: edge_cnt == prescale/2.
  - prescale and par_en/par_typ are latched on the IDLE→START transition. Changes mid-frame have no effect.
- States:
  - IDLE: when rx_in == 0, go to START with edge_cnt = 1 (the detecting cycle counts as edge 0).
  - START: at the sample point, if the sampled bit is 1, treat it as a glitch and return to IDLE with no pulses. Otherwise continue to the end of the bit period, then go to DATA.
  - DATA: at each sample point, shift the sampled bit into bit position bit_cnt (LSB first). After DATA_WIDTH bit periods, go to PARITY if par_en, else STOP.
  - PARITY: at the sample point, compare with the expected parity. Expected = XOR of the data bits (even); inverted for odd. Store a mismatch flag. At the end of the bit period, go to STOP.
  - STOP: at the sample point, evaluate the frame and go directly to IDLE on the same edge. This allows back-to-back frames whose next start bit begins a half bit later.
- Frame result (one cycle after the stop sample):
  - Good frame (stop=1 and no parity mismatch): data_valid = 1 and p_data updates.
  - Parity mismatch: par_err = 1; p_data is not updated; no data_valid.
  - Stop sampled 0: stop_err = 1; p_data is not updated; no data_valid.
  - Both errors may pulse in the same cycle.
- A low line persisting in IDLE after a stop_err starts a new frame immediately. This is accepted behaviour (break condition produces repeated stop_err).
- Illegal prescale values: behaviour undefined; the verifier constrains to 8/16/32.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of samples at edge_cnt == prescale/2-1, prescale/2 and prescale/2+1. The decision is taken at prescale/2+1; all subsequent timing is unchanged.
- Undefined: the bit value is the single sample at prescale/2.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP).
  - parity type constants (PAR_EVEN = 0, PAR_ODD = 1), shared with the TX side.
  - legal prescale constants.
- One natural sub-module, uart_rx_sampler: owns edge_cnt, the sample strobe and the optional majority vote, and outputs sampled_bit, sample_stb and bit_done to the FSM.

Test Plan:
- prescale=8, par_en=1, par_typ=0, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1) → data_valid pulses once, p_data = 0xA5, no errors.
- Same frame but parity bit driven 1 → par_err pulse, data_valid stays 0, p_data keeps its previous value.
- prescale=16, par_en=0, frame 0x3C with stop bit driven 0 → stop_err pulse, no data_valid.
- rx_in low for 3 cycles in IDLE at prescale=16, then high → returns to IDLE; no pulses. The next frame 0x81 is received correctly.
- Back-to-back frames 0x55 then 0xAA at prescale=32, par_en=1, par_typ=1, no idle gap → two data_valid pulses with p_data 0x55 then 0xAA.
- Assert rst mid-DATA of frame 0xFF, then send 0x12 → no pulse for the aborted frame; 0x12 is received. With UART_RX_MAJORITY_EN, a one-cycle glitch at the center sample of a data bit does not corrupt the word.
